filter_frame_sequencer: RTL and testbench

Frame-synchronous controller that selects the active video filter from the slide switches and drives the filter chooser's select input. It sits between the board switches and the filter chooser, in the TD_CLK27 domain beside VGA_Ctrl. Requested changes are accepted only after the request has been stable for a number of frames. The block then mutes the video for one full frame and commits the new selection on a vertical-sync boundary, so the display never tears mid-frame. An auto-cycle mode steps through all filters at a fixed frame interval.

---
 rtl/filter_frame_sequencer_if.sv | 13 +
 rtl/filter_frame_sequencer.sv | 137 +++++++++++++
 tb/tb_filter_frame_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/filter_frame_sequencer_if.sv
// Switch/VSYNC inputs and filter-select outputs of the frame sequencer.
// master drives the switches and sync, slave is the sequencer itself.
interface filter_frame_sequencer_if;
    logic       iVGA_VS;
    logic [9:0] iSW;
    logic [3:0] oFilter_Sel;
    logic       oMute;
    logic       oBusy;
    logic [7:0] oFrame_Cnt;

    modport master (output iVGA_VS, iSW, input oFilter_Sel, oMute, oBusy, oFrame_Cnt);
    modport slave  (input iVGA_VS, iSW, output oFilter_Sel, oMute, oBusy, oFrame_Cnt);
endinterface

// File: rtl/filter_frame_sequencer.sv
// Frame-synchronous filter selector: debounces switch requests over frames,
// mutes for one frame, and commits on a VSYNC boundary; optional auto-cycle.
module filter_frame_sequencer #(
    parameter int N_FILTERS       = 8,
    parameter int STABLE_FRAMES   = 3,
    parameter int FRAMES_PER_STEP = 60
) (
    input logic                     iCLK,
    input logic                     iRST,
    filter_frame_sequencer_if.slave bus
);
    localparam logic [4:0] NF   = 5'(N_FILTERS);
    localparam logic [3:0] LAST = 4'(N_FILTERS - 1);
    localparam logic [3:0] SF   = 4'(STABLE_FRAMES);
    localparam logic [7:0] FPS  = 8'(FRAMES_PER_STEP);

    typedef enum logic [1:0] {IDLE, ARM, MUTE, AUTO} state_t;

    state_t     state, state_nxt;
    logic [3:0] cand, cand_nxt;
    logic [3:0] stab, stab_nxt;
    logic [7:0] step, step_nxt;
    logic [3:0] sel, sel_nxt;
    logic       mute, busy;
    logic       vs_q;
    logic [7:0] frame_cnt;

    logic       fb, freeze, auto_en;
    logic [3:0] req;

    assign fb      = vs_q & ~bus.iVGA_VS;
    assign freeze  = bus.iSW[8];
    assign auto_en = bus.iSW[9];
    // Out-of-range selections fall back to the pass-through filter.
    assign req     = ({1'b0, bus.iSW[3:0]} < NF) ? bus.iSW[3:0] : 4'd0;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= IDLE;
            cand      <= 4'd0;
            stab      <= 4'd0;
            step      <= 8'd0;
            sel       <= 4'd0;
            mute      <= 1'b0;
            busy      <= 1'b0;
            vs_q      <= 1'b1;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            stab      <= stab_nxt;
            step      <= step_nxt;
            sel       <= sel_nxt;
            mute      <= (state_nxt == MUTE);
            busy      <= (state_nxt == ARM) || (state_nxt == MUTE);
            vs_q      <= bus.iVGA_VS;
            if (fb) frame_cnt <= frame_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        stab_nxt  = stab;
        step_nxt  = step;
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                if (!freeze) begin
                    if (auto_en) begin
                        state_nxt = AUTO;
                        step_nxt  = 8'd0;
                    end else if (req != sel) begin
                        state_nxt = ARM;
                        cand_nxt  = req;
                        stab_nxt  = 4'd0;
                    end
                end
            end
            ARM: begin
                if (freeze) begin
                    state_nxt = IDLE;
                    stab_nxt  = 4'd0;
                end else if (auto_en) begin
                    state_nxt = AUTO;
                    step_nxt  = 8'd0;
                    stab_nxt  = 4'd0;
                end else if (fb) begin
                    if (req == sel) begin
                        state_nxt = IDLE;
                        stab_nxt  = 4'd0;
                    end else if (req == cand) begin
                        // Request held across this boundary; accept once enough have passed.
                        if (stab + 4'd1 == SF) begin
                            state_nxt = MUTE;
                            stab_nxt  = 4'd0;
                        end else begin
                            stab_nxt  = stab + 4'd1;
                        end
                    end else begin
                        cand_nxt  = req;
                        stab_nxt  = 4'd0;
                    end
                end
            end
            MUTE: begin
                // Commit happens even under freeze; freeze only holds the state that follows.
                if (fb) begin
                    sel_nxt   = cand;
                    step_nxt  = 8'd0;
                    state_nxt = (auto_en && !freeze) ? AUTO : IDLE;
                end
            end
            AUTO: begin
                if (!freeze) begin
                    if (!auto_en) begin
                        state_nxt = IDLE;
                    end else if (fb) begin
                        if (step + 8'd1 == FPS) begin
                            cand_nxt  = (sel == LAST) ? 4'd0 : sel + 4'd1;
                            step_nxt  = 8'd0;
                            state_nxt = MUTE;
                        end else begin
                            step_nxt  = step + 8'd1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.oFilter_Sel = sel;
    assign bus.oMute       = mute;
    assign bus.oBusy       = busy;
    assign bus.oFrame_Cnt  = frame_cnt;
endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Directed bench for filter_frame_sequencer (N_FILTERS=8, STABLE_FRAMES=3, FRAMES_PER_STEP=4).
module tb_filter_frame_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    filter_frame_sequencer_if bus ();

    filter_frame_sequencer #(
        .N_FILTERS(8), .STABLE_FRAMES(3), .FRAMES_PER_STEP(4)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One frame: VSYNC low for one cycle (one boundary), then high.
    task automatic frame();
        @(negedge clk) bus.iVGA_VS = 1'b0;
        @(negedge clk) bus.iVGA_VS = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // {sel, mute, busy}
    function automatic logic [5:0] obs();
        return {bus.oFilter_Sel, bus.oMute, bus.oBusy};
    endfunction

    task automatic test_reset();
        bus.iVGA_VS = 1'b1;
        bus.iSW     = 10'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({obs(), bus.oFrame_Cnt} !== 14'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", {obs(), bus.oFrame_Cnt}, 14'd0);
        end
        rst = 1'b0;
        repeat (5) frame();
        checks++;
        if ({obs(), bus.oFrame_Cnt} !== {6'b0000_0_0, 8'd5}) begin
            failures++;
            $display("FAIL five_frames got=%h exp=%h", {obs(), bus.oFrame_Cnt}, {6'b0, 8'd5});
        end
    endtask

    task automatic test_clamp();
        bus.iSW = 10'd12;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== {4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL clamp_idle got=%h exp=%h", obs(), 6'd0);
        end
        repeat (3) frame();
        checks++;
        if (obs() !== {4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL clamp_frames got=%h exp=%h", obs(), 6'd0);
        end
    endtask

    task automatic test_toggle();
        logic [3:0] pat [5] = '{4'd5, 4'd2, 4'd5, 4'd2, 4'd5};
        for (int i = 0; i < 5; i++) begin
            bus.iSW = {6'd0, pat[i]};
            frame();
            checks++;
            if (obs() !== {4'd0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL toggle_%0d got=%h exp=%h", i, obs(), {4'd0, 2'b01});
            end
        end
        // Hold 2: first boundary retargets, then 3 stable boundaries accept.
        bus.iSW = 10'd2;
        repeat (3) frame();
        checks++;
        if (obs() !== {4'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL toggle_hold_arm got=%h exp=%h", obs(), {4'd0, 2'b01});
        end
        frame();
        checks++;
        if (obs() !== {4'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL toggle_hold_mute got=%h exp=%h", obs(), {4'd0, 2'b11});
        end
        frame();
        checks++;
        if (obs() !== {4'd2, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL toggle_commit got=%h exp=%h", obs(), {4'd2, 2'b00});
        end
    endtask

    task automatic test_manual();
        logic [5:0] exp [4] = '{{4'd2, 2'b01}, {4'd2, 2'b01}, {4'd2, 2'b11}, {4'd5, 2'b00}};
        bus.iSW = 10'd5;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== {4'd2, 2'b01}) begin
            failures++;
            $display("FAIL manual_arm got=%h exp=%h", obs(), {4'd2, 2'b01});
        end
        for (int i = 0; i < 4; i++) begin
            frame();
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL manual_fb%0d got=%h exp=%h", i + 1, obs(), exp[i]);
            end
        end
    endtask

    task automatic test_freeze();
        bus.iSW = 10'd3;
        repeat (2) @(negedge clk);
        frame();
        checks++;
        if (obs() !== {4'd5, 2'b01}) begin
            failures++;
            $display("FAIL freeze_arm got=%h exp=%h", obs(), {4'd5, 2'b01});
        end
        bus.iSW = 10'h103;
        @(negedge clk);
        checks++;
        if (obs() !== {4'd5, 2'b00}) begin
            failures++;
            $display("FAIL freeze_drop got=%h exp=%h", obs(), {4'd5, 2'b00});
        end
        repeat (3) frame();
        checks++;
        if (obs() !== {4'd5, 2'b00}) begin
            failures++;
            $display("FAIL freeze_hold got=%h exp=%h", obs(), {4'd5, 2'b00});
        end
        bus.iSW = 10'd5;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== {4'd5, 2'b00}) begin
            failures++;
            $display("FAIL freeze_release got=%h exp=%h", obs(), {4'd5, 2'b00});
        end
    endtask

    task automatic test_reset_in_mute();
        bus.iSW = 10'd1;
        repeat (2) @(negedge clk);
        repeat (3) frame();
        checks++;
        if (obs() !== {4'd5, 2'b11}) begin
            failures++;
            $display("FAIL rst_mute_pre got=%h exp=%h", obs(), {4'd5, 2'b11});
        end
        rst = 1'b1;
        bus.iSW = 10'd0;
        @(negedge clk);
        checks++;
        if ({obs(), bus.oFrame_Cnt} !== 14'd0) begin
            failures++;
            $display("FAIL rst_mute_post got=%h exp=%h", {obs(), bus.oFrame_Cnt}, 14'd0);
        end
        rst = 1'b0;
    endtask

    task automatic test_auto();
        logic [5:0] e;
        bus.iSW = 10'h200;
        repeat (2) @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            frame();
            e = {4'((k / 5) % 8), (k % 5 == 4), (k % 5 == 4)};
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL auto_fb%0d got=%h exp=%h", k, obs(), e);
            end
        end
        checks++;
        if (bus.oFrame_Cnt !== 8'd40) begin
            failures++;
            $display("FAIL auto_frame_cnt got=%0d exp=%0d", bus.oFrame_Cnt, 40);
        end
        bus.iSW = 10'd0;
        repeat (2) @(negedge clk);
        frame();
        checks++;
        if (obs() !== 6'd0) begin
            failures++;
            $display("FAIL auto_exit got=%h exp=%h", obs(), 6'd0);
        end
    endtask

    initial begin
        test_reset();
        test_clamp();
        test_toggle();
        test_manual();
        test_freeze();
        test_reset_in_mute();
        test_auto();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
